// File: rtl/uart_tx_framer.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits; first start bit 1 cycle after accept.
// One-entry holding register; tx_ready (registered) drops while it is full, so frames can run back-to-back.
module uart_tx_framer #(
   parameter int CLOCKS_PER_BIT = 104,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       serial_tx,
   output logic       tx_busy
);

   localparam int CW = (CLOCKS_PER_BIT < 2) ? 1 : $clog2(CLOCKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLOCKS_PER_BIT - 1);

   if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_framer: CLOCKS_PER_BIT must be >= 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_framer: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_framer: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            stop_idx_q, stop_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [7:0]      hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic            serial_q, serial_d;
   logic            ready_q, busy_q;
   logic            bit_end, stop_last, load;

   assign bit_end   = (baud_q == BAUD_LAST);
   assign stop_last = (STOP_BITS == 1) || stop_idx_q;

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      shift_d     = shift_q;
      par_d       = par_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      serial_d    = serial_q;
      load        = 1'b0;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            load = hold_full_q;
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               serial_d  = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = 3'd0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  stop_idx_d = 1'b0;
                  if (PARITY != 0) begin
                     state_d  = S_PARITY;
                     serial_d = par_q;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  serial_d  = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d    = S_STOP;
               serial_d   = 1'b1;
               stop_idx_d = 1'b0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (stop_last) begin
                  if (hold_full_q) load = 1'b1;
                  else state_d = S_IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Hold-to-shift transfer; parity is fixed here so the data path never needs the original byte again.
      if (load) begin
         state_d     = S_START;
         serial_d    = 1'b0;
         shift_d     = hold_q;
         par_d       = (^hold_q) ^ (PARITY == 1);
         hold_full_d = 1'b0;
         baud_d      = '0;
      end

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_byte;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_idx_q   <= 3'd0;
         stop_idx_q  <= 1'b0;
         shift_q     <= 8'h00;
         par_q       <= 1'b0;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         serial_q    <= 1'b1;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         serial_q    <= serial_d;
         ready_q     <= !hold_full_d;
         busy_q      <= (state_d != S_IDLE) || hold_full_d;
      end
   end

   assign tx_ready  = ready_q;
   assign serial_tx = serial_q;
   assign tx_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four instances (no parity, even, odd, two stop bits) at 4 clocks per bit,
// checked every cycle against a frame-level line model plus literal expectations.
module tb_uart_tx_framer;

   localparam int CPB = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] tx_byte  [4];
   logic       tx_valid [4];
   logic       tx_ready [4];
   logic       serial_tx[4];
   logic       tx_busy  [4];

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_framer #(
         .CLOCKS_PER_BIT(CPB),
         .PARITY        ((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
         .STOP_BITS     ((g == 3) ? 2 : 1)
      ) u_dut (
         .clock    (clock),
         .reset_n  (reset_n),
         .tx_byte  (tx_byte[g]),
         .tx_valid (tx_valid[g]),
         .tx_ready (tx_ready[g]),
         .serial_tx(serial_tx[g]),
         .tx_busy  (tx_busy[g])
      );
   end

   function automatic int par_of(int g);
      return (g == 1) ? 2 : ((g == 2) ? 1 : 0);
   endfunction

   function automatic int stop_of(int g);
      return (g == 3) ? 2 : 1;
   endfunction

   // ---------------- line model ----------------
   bit         lq [4][$];
   int         acc_log [4][$];
   int         start_log [4][$];
   bit         hold_m [4];
   logic [7:0] hb_m [4];
   bit         exp_ser [4];
   bit         exp_rdy [4];
   bit         exp_busy [4];
   int         cyc = 0;

   initial begin
      for (int g = 0; g < 4; g++) begin
         hold_m[g] = 0; hb_m[g] = 8'h00;
         exp_ser[g] = 1; exp_rdy[g] = 1; exp_busy[g] = 0;
         tx_byte[g] = 8'h00; tx_valid[g] = 1'b0;
      end
   end

   function automatic void build(int g, logic [7:0] b);
      bit bits[$];
      int ones;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      ones = $countones(b);
      if (par_of(g) == 2) bits.push_back((ones % 2) == 1);
      if (par_of(g) == 1) bits.push_back((ones % 2) == 0);
      for (int s = 0; s < stop_of(g); s++) bits.push_back(1'b1);
      foreach (bits[i]) for (int c = 0; c < CPB; c++) lq[g].push_back(bits[i]);
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int g = 0; g < 4; g++) begin
            lq[g].delete();
            hold_m[g] = 0;
            exp_ser[g] = 1; exp_rdy[g] = 1; exp_busy[g] = 0;
         end
      end else begin
         cyc++;
         for (int g = 0; g < 4; g++) begin
            bit acc, inframe;
            acc = tx_valid[g] && !hold_m[g];
            inframe = 0;
            if (lq[g].size() == 0 && hold_m[g]) begin
               build(g, hb_m[g]);
               hold_m[g] = 0;
               start_log[g].push_back(cyc);
            end
            if (lq[g].size() > 0) begin
               exp_ser[g] = lq[g].pop_front();
               inframe = 1;
            end else begin
               exp_ser[g] = 1;
            end
            if (acc) begin
               hold_m[g] = 1;
               hb_m[g] = tx_byte[g];
               acc_log[g].push_back(cyc);
            end
            exp_rdy[g]  = !hold_m[g];
            exp_busy[g] = inframe || hold_m[g];
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("serial_tx[%0d]", g), int'(serial_tx[g]), int'(exp_ser[g]));
         chk($sformatf("tx_ready[%0d]", g),  int'(tx_ready[g]),  int'(exp_rdy[g]));
         chk($sformatf("tx_busy[%0d]", g),   int'(tx_busy[g]),   int'(exp_busy[g]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int g, input logic [7:0] b, input bit keep);
      int n0;
      bit done;
      n0 = acc_log[g].size();
      done = 0;
      @(negedge clock);
      tx_byte[g]  = b;
      tx_valid[g] = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clock);
         #1;
         done = (acc_log[g].size() != n0);
      end
      if (!done) chk("accept_timeout", 0, 1);
      if (!keep) tx_valid[g] = 1'b0;
   endtask

   task automatic probe(input int g, output int pre, output int len, output logic [63:0] ln);
      bit stop;
      ln = '0; len = 0; stop = 0;
      @(negedge clock);
      pre = int'(serial_tx[g]);
      for (int i = 0; i < 200 && !stop; i++) begin
         @(negedge clock);
         if (!tx_busy[g]) stop = 1;
         else begin
            if (len < 64) ln[len] = serial_tx[g];
            len++;
         end
      end
      if (!stop) chk("probe_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int g);
      bit idle;
      idle = 0;
      for (int i = 0; i < 500 && !idle; i++) begin
         @(negedge clock);
         idle = !exp_busy[g];
      end
      if (!idle) chk("idle_timeout", 0, 1);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int pre, len, na, ns, run;
      logic [63:0] ln;
      logic [9:0]  pat;
      bit          seen;

      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_serial", int'(serial_tx[0]), 1);
      chk("rst_ready",  int'(tx_ready[0]),  1);
      chk("rst_busy",   int'(tx_busy[0]),   0);
      reset_n = 1'b1;
      @(negedge clock);

      // 0x55, no parity: start, 1,0,1,0,1,0,1,0, stop
      send(0, 8'h55, 0);
      probe(0, pre, len, ln);
      pat = 10'b10_1010_1010;
      chk("t1_pre_idle", pre, 1);
      chk("t1_fall_1cyc", int'(ln[0]), 0);
      for (int k = 0; k < 10; k++) chk($sformatf("t1_bit%0d", k), int'(ln[4*k+1]), int'(pat[k]));
      chk("t1_len", len, 40);

      // 0x07 has three ones: even parity bit 1, odd parity bit 0
      send(1, 8'h07, 0);
      probe(1, pre, len, ln);
      chk("even_par_bit", int'(ln[37]), 1);
      chk("even_len", len, 44);
      send(2, 8'h07, 0);
      probe(2, pre, len, ln);
      chk("odd_par_bit", int'(ln[37]), 0);
      chk("odd_len", len, 44);

      // back-to-back with tx_valid held high
      na = acc_log[0].size(); ns = start_log[0].size();
      send(0, 8'hA5, 1);
      send(0, 8'h3C, 0);
      wait_idle(0);
      chk("b2b_accept_gap", acc_log[0][na+1] - acc_log[0][na], 2);
      chk("b2b_start_gap", start_log[0][ns+1] - start_log[0][ns], 40);

      // backpressure: third byte waits for the held byte to move out
      na = acc_log[0].size(); ns = start_log[0].size();
      send(0, 8'h11, 1);
      send(0, 8'h22, 1);
      @(negedge clock);
      tx_byte[0] = 8'hFF;
      chk("bp_ready_low", int'(tx_ready[0]), 0);
      repeat (5) @(negedge clock);
      chk("bp_no_accept", acc_log[0].size(), na + 2);
      send(0, 8'hFF, 0);
      wait_idle(0);
      chk("bp_ff_accept_time", acc_log[0][na+2] - start_log[0][ns], 41);
      chk("bp_frames", start_log[0].size() - ns, 3);

      // reset during data bit 3 of 0xC3 (that bit is 0)
      send(0, 8'hC3, 0);
      repeat (19) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_serial", int'(serial_tx[0]), 1);
      chk("rstmid_ready",  int'(tx_ready[0]),  1);
      chk("rstmid_busy",   int'(tx_busy[0]),   0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      send(0, 8'h81, 0);
      probe(0, pre, len, ln);
      pat = 10'b11_0000_0010;
      chk("r81_pre_idle", pre, 1);
      for (int k = 0; k < 10; k++) chk($sformatf("r81_bit%0d", k), int'(ln[4*k+1]), int'(pat[k]));
      chk("r81_len", len, 40);

      // two stop bits, two zero bytes back-to-back: exactly 8 high cycles between frames
      ns = start_log[3].size();
      send(3, 8'h00, 1);
      send(3, 8'h00, 0);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock);
         seen = serial_tx[3];
      end
      run = 0;
      for (int i = 0; i < 100 && serial_tx[3]; i++) begin
         run++;
         @(negedge clock);
      end
      chk("stop2_high_run", run, 8);
      wait_idle(3);
      chk("stop2_start_gap", start_log[3][ns+1] - start_log[3][ns], 44);

      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Standalone UART transmitter that serializes bytes from a valid/ready byte stream onto a single serial line. It sends standard async frames: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. A one-entry holding register lets the next byte be accepted while the current frame shifts out, so frames can run back-to-back with no idle gap. It is the transmit-side counterpart to the UART receive path and drives the board serial_tx pin.

Parameters:
CLOCKS_PER_BIT, 104, clock cycles per serial bit (must be >= 2).
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
tx_byte  input  8  byte to transmit; sampled on handshake.
tx_valid  input  1  source has a byte on tx_byte.
tx_ready  output  1  holding register empty; byte accepted when tx_valid && tx_ready.
serial_tx  output  1  serial line, idle high (mark), registered.
tx_busy  output  1  high while a frame is in flight or the holding register is full.

Behaviour:
- Reset (asynchronous, active-low):
  - serial_tx=1, tx_ready=1, tx_busy=0, state IDLE.
  - Holding register, counters and shift register cleared.
  - Asserting reset mid-frame aborts the frame and forces serial_tx high immediately; any held byte is discarded.
- Handshake:
  - tx_ready = !hold_full, driven from a flop with no combinational path from tx_valid.
  - On tx_valid && tx_ready, tx_byte is latched into hold and hold_full is set.
  - tx_byte may change freely when no handshake occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with hold_full: on the next edge, hold moves to the shift register, hold_full clears, state goes to START, serial_tx=0.
  - serial_tx therefore falls exactly 1 cycle after the accepting edge.
  - START -> DATA after CLOCKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held for CLOCKS_PER_BIT cycles; bit index 0..7.
  - After bit 7: go to PARITY if PARITY != 0, else STOP.
  - PARITY: drives the XOR of the 8 data bits (even) or its inverse (odd) for one bit time.
  - STOP: serial_tx=1 for STOP_BITS*CLOCKS_PER_BIT cycles.
  - On the last cycle of STOP: go to START if hold_full (transfer as in IDLE, no idle cycle between frames), else go to IDLE.
- Bit timing:
  - Baud counter is $clog2(CLOCKS_PER_BIT) bits wide, counts 0..CLOCKS_PER_BIT-1, and wraps to 0 at each bit boundary.
  - Every bit lasts exactly CLOCKS_PER_BIT cycles; there is no cumulative drift.
  - Frame length = (1 + 8 + (PARITY!=0) + STOP_BITS) * CLOCKS_PER_BIT cycles.
- Hold refill:
  - A new byte may be accepted on any cycle hold is empty, including the cycle right after the hold-to-shift transfer.
  - At most one byte is queued beyond the frame in flight.
- tx_busy = (state != IDLE) || hold_full, registered alongside the state.
- Illegal parameters: CLOCKS_PER_BIT < 2, PARITY > 2, or STOP_BITS not 1 or 2 must raise an elaboration-time $error in simulation.

Test Plan:
- CLOCKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0x55 -> serial_tx goes low 1 cycle after accept, then bits 0,1,0,1,0,1,0,1,0,1, each 4 cycles. Line returns to idle 40 cycles after the start-bit edge; tx_busy falls on the same edge.
- PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0. Frame is 44 cycles at CLOCKS_PER_BIT=4.
- Back-to-back: offer 0xA5 then 0x3C with tx_valid held high -> second accept lands 2 cycles after the first. The 0x3C start bit begins exactly 40 cycles after the 0xA5 start bit with no idle cycle; tx_ready stays 0 from the second accept until the hold-to-shift transfer.
- Backpressure: with one frame in flight and hold full, offer 0xFF -> tx_ready=0, no accept. 0xFF is accepted only after the held byte transfers, and all three bytes appear on the line in order.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 -> serial_tx=1 with no clock edge, tx_ready=1, tx_busy=0. After release, send 0x81 -> clean frame, with no remnant of the aborted byte.
- STOP_BITS=2, CLOCKS_PER_BIT=4, two bytes back-to-back -> serial_tx high for exactly 8 cycles between the last data bit and the next start bit.
